nn_complex: RTL and testbench



---
 rtl/nn_complex_pkg.sv | 19 +
 rtl/nn_nand2.sv | 18 +
 rtl/nn_complex.sv | 83 ++++++++
 tb/tb_nn_complex.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/nn_complex_pkg.sv
// ============================================================================
// Module   : nn_complex_pkg
// Purpose  : Shared constants and the behavioural AO22 reference function.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_complex_pkg;

  localparam int CNT_W_DEFAULT = 8;

  function automatic logic ao22_ref(input logic a, input logic b,
                                    input logic c, input logic d);
    return (a & b) | (c & d);
  endfunction

endpackage : nn_complex_pkg

`default_nettype wire

// File: rtl/nn_nand2.sv
// ============================================================================
// Module   : nn_nand2
// Purpose  : 2-input NAND leaf cell; an inverter is this cell with x and y tied.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_nand2 (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = ~(x & y);

endmodule : nn_nand2

`default_nettype wire

// File: rtl/nn_complex.sv
// ============================================================================
// Module   : nn_complex
// Purpose  : Registered AO22 w = (a&b)|(c&d) from NAND2 cells, with an optional
//            cross-check against a behavioural reference (NN_COMPLEX_CHECK_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_complex
  import nn_complex_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             w,
  output logic             err,
  output logic [CNT_W-1:0] mis_cnt
);

  logic w_n1;
  logic w_n2;
  logic w_comb;
  logic w_q;

  // AO22 by De Morgan: NAND(NAND(a,b), NAND(c,d))
  nn_nand2 u_nand_n1  (.x(a),    .y(b),    .z(w_n1));
  nn_nand2 u_nand_n2  (.x(c),    .y(d),    .z(w_n2));
  nn_nand2 u_nand_out (.x(w_n1), .y(w_n2), .z(w_comb));

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= 1'b0;
    end else begin
      w_q <= w_comb;
    end
  end

  assign w = w_q;

`ifdef NN_COMPLEX_CHECK_EN
  logic             w_ref;
  logic             w_mismatch;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    w_ref      = ao22_ref(a, b, c, d);
    w_mismatch = (w_comb != w_ref);
    err_d      = err_q | w_mismatch;
    cnt_d      = cnt_q;
    // Saturate at all-ones rather than wrapping back to zero
    if (w_mismatch && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err     = err_q;
  assign mis_cnt = cnt_q;
`else
  assign err     = 1'b0;
  assign mis_cnt = '0;
`endif

endmodule : nn_complex

`default_nettype wire

// File: tb/tb_nn_complex.sv
// ============================================================================
// Module   : tb_nn_complex
// Purpose  : Self-checking bench for nn_complex against a truth-level model;
//            fault cases are exercised when NN_COMPLEX_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_complex;

`ifdef NN_COMPLEX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       c = 1'b0;
  logic       d = 1'b0;
  logic       w;
  logic       err;
  logic [7:0] mis_cnt;
  logic       w2;
  logic       err2;
  logic [1:0] mis_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  bit forced = 1'b0;
  bit m_w    = 1'b0;
  bit m_err  = 1'b0;
  int m_cnt8 = 0;
  int m_cnt2 = 0;

  nn_complex dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .w(w), .err(err), .mis_cnt(mis_cnt)
  );

  nn_complex #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .w(w2), .err(err2), .mis_cnt(mis_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one input vector for one cycle, advance the model, compare all outputs
  task automatic step(input logic [3:0] abcd, input logic r, input string tag);
    bit ref_w;
    bit gate_w;
    int p1;
    int p2;
    @(negedge clk);
    {a, b, c, d} = abcd;
    rst = r;
    p1 = int'(abcd[3]) * int'(abcd[2]);
    p2 = int'(abcd[1]) * int'(abcd[0]);
    ref_w  = (p1 + p2) > 0;
    // A stuck-at-1 first product NAND leaves only the c&d term visible
    gate_w = forced ? (p2 > 0) : ref_w;
    if (r) begin
      m_w = 1'b0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_w = gate_w;
      if (gate_w != ref_w) begin
        m_err  = 1'b1;
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".w"},        32'(w),        32'(m_w));
    check({tag, ".w2"},       32'(w2),       32'(m_w));
    check({tag, ".err"},      32'(err),      CHK ? 32'(m_err)  : 32'd0);
    check({tag, ".mis_cnt"},  32'(mis_cnt),  CHK ? 32'(m_cnt8) : 32'd0);
    check({tag, ".err2"},     32'(err2),     CHK ? 32'(m_err)  : 32'd0);
    check({tag, ".mis_cnt2"}, 32'(mis_cnt2), CHK ? 32'(m_cnt2) : 32'd0);
  endtask

`ifdef NN_COMPLEX_CHECK_EN
  task automatic set_fault(input bit on);
    if (on) begin
      force dut.w_n1  = 1'b1;
      force dut2.w_n1 = 1'b1;
    end else begin
      release dut.w_n1;
      release dut2.w_n1;
    end
    forced = on;
  endtask
`endif

  logic [3:0] seq [7] = '{4'b1110, 4'b1111, 4'b1100, 4'b1101, 4'b1100, 4'b0100, 4'b1100};

  initial begin
    // Reset with all inputs high, then release
    step(4'b1111, 1'b1, "rst0");
    step(4'b1111, 1'b1, "rst1");
    step(4'b1111, 1'b0, "rel");

    foreach (seq[i]) step(seq[i], 1'b0, "seq");

    for (int i = 0; i < 16; i++) step(4'(i), 1'b0, "sweep");

    // Mid-stream reset discards the pending result
    step(4'b1111, 1'b0, "pre_rst");
    step(4'b1111, 1'b1, "mid_rst");

`ifdef NN_COMPLEX_CHECK_EN
    set_fault(1'b1);
    for (int i = 0; i < 3; i++) step(4'b1100, 1'b0, "fault3");
    set_fault(1'b0);
    step(4'b1100, 1'b0, "sticky");

    set_fault(1'b1);
    step(4'b1100, 1'b1, "rst_vs_fault");
    set_fault(1'b0);

    set_fault(1'b1);
    for (int i = 0; i < 6; i++) step(4'b1101, 1'b0, "sat");
    set_fault(1'b0);
    step(4'b0000, 1'b1, "clr");
`endif

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_nn_complex

`default_nettype wire
